// File: rtl/opb_status_bank_if.sv
// OPB slave-side bus bundle for opb_status_bank; bit 0 of every bus is the MSB.
interface opb_status_bank_if;
  logic [0:31] OPB_ABus;
  logic [0:3]  OPB_BE;
  logic [0:31] OPB_DBus;
  logic        OPB_RNW;
  logic        OPB_select;
  logic        OPB_seqAddr;
  logic [0:31] Sl_DBus;
  logic        Sl_xferAck;
  logic        Sl_errAck;
  logic        Sl_retry;
  logic        Sl_toutSup;

  modport master (
    output OPB_ABus, OPB_BE, OPB_DBus, OPB_RNW, OPB_select, OPB_seqAddr,
    input  Sl_DBus, Sl_xferAck, Sl_errAck, Sl_retry, Sl_toutSup
  );

  modport slave (
    input  OPB_ABus, OPB_BE, OPB_DBus, OPB_RNW, OPB_select, OPB_seqAddr,
    output Sl_DBus, Sl_xferAck, Sl_errAck, Sl_retry, Sl_toutSup
  );
endinterface

// File: rtl/opb_status_bank.sv
// OPB status bank: C_N_CH shadowed channels with freeze/snapshot, one-cycle ack after select.
// Define STATUS_BANK_STICKY_EN to add per-channel sticky change flags at offset 0x04.
module opb_status_bank #(
  parameter logic [31:0] C_BASEADDR   = 32'h01085100,
  parameter logic [31:0] C_HIGHADDR   = 32'h010851FF,
  parameter int          C_OPB_AWIDTH = 32,
  parameter int          C_OPB_DWIDTH = 32,
  parameter int          C_N_CH       = 4,
  parameter int          C_DATA_W     = 32
) (
  input  logic                       OPB_Clk,
  input  logic                       OPB_Rst_n,
  opb_status_bank_if.slave           opb,
  input  logic [C_N_CH*C_DATA_W-1:0] user_data_in
);

  typedef enum logic [1:0] {ST_IDLE, ST_ACK, ST_WAIT} state_e;

  state_e                  state_q, state_d;
  logic                    ack_q, ack_d;
  logic [C_OPB_DWIDTH-1:0] dbus_q, dbus_d;
  logic                    freeze_q, freeze_d;
  logic [C_DATA_W-1:0]     shadow_q [C_N_CH];
  logic [C_DATA_W-1:0]     shadow_d [C_N_CH];
  logic [C_DATA_W-1:0]     live [C_N_CH];

  logic [C_OPB_AWIDTH-1:0] addr;
  logic [C_OPB_DWIDTH-1:0] wdat;
  logic [3:0]              be;
  logic [31:0]             off;
  logic [29:0]             word_idx;
  logic                    in_win;
  logic                    wr_en;
  logic                    ctrl_wr;
  logic                    snap;
  logic [C_OPB_DWIDTH-1:0] rd_word;
  logic                    unused_ok;

  // Packed assignment maps bus bit 0 onto word bit 31; be[0] is the lane of word[7:0].
  assign addr     = opb.OPB_ABus;
  assign wdat     = opb.OPB_DBus;
  assign be       = opb.OPB_BE;
  assign in_win   = (32'(addr) >= C_BASEADDR) && (32'(addr) <= C_HIGHADDR);
  assign off      = 32'(addr) - C_BASEADDR;
  assign word_idx = off[31:2];

  assign wr_en   = (state_q == ST_ACK) && !opb.OPB_RNW;
  assign ctrl_wr = wr_en && (word_idx == 30'd0) && be[0];
  assign snap    = ctrl_wr && wdat[0];

  always_comb begin
    for (int i = 0; i < C_N_CH; i++) begin
      live[i] = user_data_in[i*C_DATA_W +: C_DATA_W];
    end
  end

`ifdef STATUS_BANK_STICKY_EN
  logic [C_DATA_W-1:0] prev_q [C_N_CH];
  logic [C_DATA_W-1:0] prev_d [C_N_CH];
  logic [C_N_CH-1:0]   sticky_q, sticky_d;
  logic [C_N_CH-1:0]   chg;
  logic [C_N_CH-1:0]   clr;
  logic                sticky_wr;

  assign sticky_wr = wr_en && (word_idx == 30'd1);

  // A change seen in the same cycle as a clear re-sets the flag.
  always_comb begin
    chg = '0;
    clr = '0;
    for (int i = 0; i < C_N_CH; i++) begin
      prev_d[i] = live[i];
      chg[i]    = (live[i] != prev_q[i]);
      clr[i]    = sticky_wr && be[i/8] && wdat[i];
    end
    sticky_d = (sticky_q & ~clr) | chg;
  end

  always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
    if (!OPB_Rst_n) begin
      sticky_q <= '0;
      for (int i = 0; i < C_N_CH; i++) begin
        prev_q[i] <= '0;
      end
    end else begin
      sticky_q <= sticky_d;
      for (int i = 0; i < C_N_CH; i++) begin
        prev_q[i] <= prev_d[i];
      end
    end
  end
`endif

  always_comb begin
    rd_word = '0;
    if (word_idx == 30'd0) begin
      rd_word[1] = freeze_q;
    end
`ifdef STATUS_BANK_STICKY_EN
    if (word_idx == 30'd1) begin
      rd_word[C_N_CH-1:0] = sticky_q;
    end
`endif
    for (int i = 0; i < C_N_CH; i++) begin
      if (word_idx == 30'(i + 2)) begin
        rd_word[C_DATA_W-1:0] = shadow_q[i];
      end
    end
  end

  // Shadows track live data until frozen; a snap reloads them regardless of freeze.
  always_comb begin
    freeze_d = freeze_q;
    if (ctrl_wr) begin
      freeze_d = wdat[1];
    end
    for (int i = 0; i < C_N_CH; i++) begin
      shadow_d[i] = shadow_q[i];
      if (!freeze_q || snap) begin
        shadow_d[i] = live[i];
      end
    end
  end

  always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
    if (!OPB_Rst_n) begin
      freeze_q <= 1'b0;
      for (int i = 0; i < C_N_CH; i++) begin
        shadow_q[i] <= '0;
      end
    end else begin
      freeze_q <= freeze_d;
      for (int i = 0; i < C_N_CH; i++) begin
        shadow_q[i] <= shadow_d[i];
      end
    end
  end

  // Read data is latched on the IDLE->ACK transition so it reflects pre-snap shadows.
  always_comb begin
    state_d = state_q;
    ack_d   = 1'b0;
    dbus_d  = '0;
    case (state_q)
      ST_IDLE: begin
        if (opb.OPB_select && in_win) begin
          state_d = ST_ACK;
          ack_d   = 1'b1;
          if (opb.OPB_RNW) begin
            dbus_d = rd_word;
          end
        end
      end
      ST_ACK: begin
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (!opb.OPB_select) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
    if (!OPB_Rst_n) begin
      state_q <= ST_IDLE;
      ack_q   <= 1'b0;
      dbus_q  <= '0;
    end else begin
      state_q <= state_d;
      ack_q   <= ack_d;
      dbus_q  <= dbus_d;
    end
  end

  assign opb.Sl_DBus    = dbus_q;
  assign opb.Sl_xferAck = ack_q;
  assign opb.Sl_errAck  = 1'b0;
  assign opb.Sl_retry   = 1'b0;
  assign opb.Sl_toutSup = 1'b0;

  assign unused_ok = ^{opb.OPB_seqAddr, off[1:0], wdat, be};

endmodule
